// File: rtl/fib_bcd_converter_pkg.sv
// Shared widths and FSM encodings for the Fibonacci value BCD converter.
package fib_bcd_converter_pkg;

    localparam int FIB_DATA_W = 8;
    localparam int BCD_DIG_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef logic [BCD_DIG_W-1:0] bcd_digit_t;

endpackage

// File: rtl/fib_bcd_converter_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import fib_bcd_converter_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    assign dout = (din >= bcd_digit_t'(5)) ? din + bcd_digit_t'(3) : din;

endmodule

// File: rtl/fib_bcd_converter.sv
// Sequential shift-add-3 binary to BCD converter that follows a free-running value bus.
module fib_bcd_converter
    import fib_bcd_converter_pkg::*;
#(
    parameter int DATA_W = FIB_DATA_W,
    parameter int NDIG   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         din,
    output logic [BCD_DIG_W*NDIG-1:0] bcd,
    output logic                      valid,
    output logic                      busy,
    output logic                      missed
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [1:0]                        state;
    logic [DATA_W-1:0]                 din_q;
    logic [DATA_W-1:0]                 last_conv;
    logic [DATA_W-1:0]                 shreg;
    logic                              force_conv;
    logic [CNT_W-1:0]                  cnt;
    logic [NDIG-1:0][BCD_DIG_W-1:0]    acc;
    logic [NDIG-1:0][BCD_DIG_W-1:0]    acc_adj;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_dig
            bcd_digit_adj u_adj (
                .din  (acc[g]),
                .dout (acc_adj[g])
            );
        end
    endgenerate

    assign busy = (state != ST_IDLE);

    // The generator has no handshake, so its bus is sampled every cycle, reset or not.
    always_ff @(posedge clk) begin
        din_q <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            force_conv <= 1'b1;
            last_conv  <= '0;
            shreg      <= '0;
            acc        <= '0;
            cnt        <= '0;
            bcd        <= '0;
            valid      <= 1'b0;
            missed     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (busy && (din_q != last_conv))
                missed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (force_conv || (din_q != last_conv)) begin
                        shreg      <= din_q;
                        acc        <= '0;
                        cnt        <= '0;
                        last_conv  <= din_q;
                        force_conv <= 1'b0;
                        state      <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {acc, shreg} <= {acc_adj, shreg} << 1;
                    cnt          <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    bcd   <= acc;
                    valid <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
